stack_cmd_sequencer: RTL and testbench

Upstream front-end for the 5-entry, 4-bit stack. Accepts one host request at a time over a valid/ready handshake and drives the stack's `COMMAND`, `INDEX` and shared tri-state `IO_DATA` bus for exactly one cycle per operation. For POP and GET it captures the returned nibble and presents a response with an error flag. It keeps a shadow occupancy count (0..5) so the host sees FULL/EMPTY without querying the stack.

---
 rtl/stack_cmd_sequencer_if.sv | 30 +++
 rtl/stack_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_stack_cmd_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_cmd_sequencer_if.sv
// Host and stack-control signal bundle for stack_cmd_sequencer.
// The tri-state IO_DATA bus stays a plain inout port on the module.
interface stack_cmd_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [3:0] REQ_DATA;
    logic [2:0] REQ_INDEX;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [2:0] COUNT;
    logic       FULL;
    logic       EMPTY;
    logic [1:0] COMMAND;
    logic [2:0] INDEX;

    modport master (
        output REQ_VALID, REQ_OP, REQ_DATA, REQ_INDEX, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        input  COUNT, FULL, EMPTY, COMMAND, INDEX
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_DATA, REQ_INDEX, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        output COUNT, FULL, EMPTY, COMMAND, INDEX
    );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Front-end sequencer for the 5-entry 4-bit stack with shadow occupancy.
// Define STACK_SEQ_BOUNDS_CHECK_EN to reject illegal requests with RSP_ERR.
module stack_cmd_sequencer #(
    parameter int DEPTH = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    stack_cmd_sequencer_if.slave bus,
    inout  wire  [3:0]           IO_DATA
);
    localparam logic [2:0] LP_DEPTH = 3'(DEPTH);
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_GET  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t     r_state;
    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [3:0] r_rsp_data;
    logic       r_rsp_err;
    logic [2:0] r_count;
    logic [1:0] r_cmd;
    logic [2:0] r_idx;
    logic       r_drv;
    logic [3:0] r_wdata;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_illegal;

    assign w_full   = (r_count == LP_DEPTH);
    assign w_empty  = (r_count == 3'd0);
    assign w_accept = (r_state == S_IDLE) && r_req_ready && bus.REQ_VALID;

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
    assign w_illegal = ((bus.REQ_OP == OP_PUSH) && w_full)
                    || ((bus.REQ_OP == OP_POP) && w_empty)
                    || ((bus.REQ_OP == OP_GET) && (bus.REQ_INDEX >= r_count));
`else
    assign w_illegal = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'd0;
            r_rsp_err   <= 1'b0;
            r_count     <= 3'd0;
            r_cmd       <= OP_NOP;
            r_idx       <= 3'd0;
            r_drv       <= 1'b0;
            r_wdata     <= 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_wdata     <= bus.REQ_DATA;
                        if (bus.REQ_OP == OP_NOP || w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_illegal;
                            r_rsp_data  <= 4'd0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_cmd   <= bus.REQ_OP;
                            r_idx   <= (bus.REQ_OP == OP_GET) ? bus.REQ_INDEX : 3'd0;
                            r_drv   <= (bus.REQ_OP == OP_PUSH);
                        end
                    end
                end
                S_ISSUE: begin
                    r_state     <= S_RESP;
                    r_cmd       <= OP_NOP;
                    r_idx       <= 3'd0;
                    r_drv       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    // read data is on the bus from the stack during this cycle
                    r_rsp_data  <= (r_cmd == OP_POP || r_cmd == OP_GET) ? IO_DATA : 4'd0;
                    if (r_cmd == OP_PUSH && !w_full)
                        r_count <= r_count + 3'd1;
                    else if (r_cmd == OP_POP && !w_empty)
                        r_count <= r_count - 3'd1;
                end
                S_RESP: begin
                    if (bus.RSP_READY) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= 4'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IO_DATA       = r_drv ? r_wdata : 4'bzzzz;
    assign bus.REQ_READY = r_req_ready;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_DATA  = r_rsp_data;
    assign bus.RSP_ERR   = r_rsp_err;
    assign bus.COUNT     = r_count;
    assign bus.FULL      = w_full;
    assign bus.EMPTY     = w_empty;
    assign bus.COMMAND   = r_cmd;
    assign bus.INDEX     = r_idx;
endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Self-checking bench for stack_cmd_sequencer with a behavioural stack model.
// Response scoreboard plus per-scenario inline checks; honours STACK_SEQ_BOUNDS_CHECK_EN.
module tb_stack_cmd_sequencer;
    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] GET  = 2'b11;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    stack_cmd_sequencer_if bus();
    wire [3:0] io_bus;

    stack_cmd_sequencer #(.DEPTH(5)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus),
        .IO_DATA (io_bus)
    );

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q [$];
    logic [4:0] exp_e;

    // behavioural model of the attached stack
    logic [3:0] stk [5];
    int         sp;
    int         pos;
    logic       stk_en;
    logic [3:0] stk_out;

    always_comb begin
        pos     = sp - 1 - int'(bus.INDEX);
        stk_en  = (bus.COMMAND == POP) || (bus.COMMAND == GET);
        stk_out = 4'd0;
        if (pos >= 0 && pos < 5) stk_out = stk[pos];
    end

    assign io_bus = stk_en ? stk_out : 4'bzzzz;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sp <= 0;
        end else if (bus.COMMAND == PUSH) begin
            if (sp < 5) begin
                stk[sp] <= io_bus;
                sp <= sp + 1;
            end else begin
                for (int i = 0; i < 4; i++) stk[i] <= stk[i+1];
                stk[4] <= io_bus;
            end
        end else if (bus.COMMAND == POP) begin
            if (sp > 0) sp <= sp - 1;
        end
    end

    // scoreboard: one expected {err,data} per response handshake
    always @(negedge CLK) begin
        if (RESET && bus.RSP_VALID && bus.RSP_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%0d err=%0b, none expected",
                         bus.RSP_DATA, bus.RSP_ERR);
            end else begin
                exp_e = exp_q.pop_front();
                if (bus.RSP_DATA !== exp_e[3:0] || bus.RSP_ERR !== exp_e[4]) begin
                    errors++;
                    $display("FAIL rsp: got data=%0d err=%0b, expected data=%0d err=%0b",
                             bus.RSP_DATA, bus.RSP_ERR, exp_e[3:0], exp_e[4]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = op;
        bus.REQ_DATA  = d;
        bus.REQ_INDEX = idx;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.REQ_READY) begin
                @(posedge CLK);
                #1;
                bus.REQ_VALID = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: op=%0d not accepted, expected acceptance", op);
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0 && !bus.RSP_VALID) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d responses pending, expected 0", exp_q.size());
    endtask

    task automatic chk_count(input logic [2:0] c);
        checks++;
        if (bus.COUNT !== c || bus.FULL !== (c == 3'd5) || bus.EMPTY !== (c == 3'd0)) begin
            errors++;
            $display("FAIL count: got %0d full=%0b empty=%0b, expected %0d",
                     bus.COUNT, bus.FULL, bus.EMPTY, c);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.REQ_READY !== 1'b0 || bus.RSP_VALID !== 1'b0 || bus.RSP_DATA !== 4'd0
            || bus.RSP_ERR !== 1'b0 || bus.COMMAND !== 2'b00 || bus.INDEX !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%0b rv=%0b rd=%0d re=%0b cmd=%0d idx=%0d, expected all 0",
                     bus.REQ_READY, bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ERR, bus.COMMAND, bus.INDEX);
        end
        chk_count(3'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %0b, expected 0", bus.REQ_READY);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %0b, expected 1", bus.REQ_READY);
        end
    endtask

    task automatic push_ok(input logic [3:0] v, input logic [2:0] c_after);
        exp_q.push_back({1'b0, 4'd0});
        send(PUSH, v, 3'd0);
        @(negedge CLK);
        checks++;
        if (bus.COMMAND !== PUSH || bus.INDEX !== 3'd0 || io_bus !== v) begin
            errors++;
            $display("FAIL push_issue: cmd=%0d idx=%0d io=%0d, expected cmd=1 idx=0 io=%0d",
                     bus.COMMAND, bus.INDEX, io_bus, v);
        end
        @(negedge CLK);
        checks++;
        if (bus.COMMAND !== NOP || bus.RSP_VALID !== 1'b1) begin
            errors++;
            $display("FAIL push_after: cmd=%0d rv=%0b, expected cmd=0 rv=1",
                     bus.COMMAND, bus.RSP_VALID);
        end
        drain();
        chk_count(c_after);
    endtask

    task automatic read_ok(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] v);
        exp_q.push_back({1'b0, v});
        send(op, 4'hF, idx);
        @(negedge CLK);
        checks++;
        if (bus.COMMAND !== op || bus.INDEX !== ((op == GET) ? idx : 3'd0) || io_bus !== v) begin
            errors++;
            $display("FAIL read_issue: cmd=%0d idx=%0d io=%0d, expected cmd=%0d idx=%0d io=%0d",
                     bus.COMMAND, bus.INDEX, io_bus, op, idx, v);
        end
        drain();
    endtask

    task automatic test_push();
        for (int i = 1; i <= 5; i++) push_ok(4'(i), 3'(i));
    endtask

    task automatic test_get();
        read_ok(GET, 3'd0, 4'd5);
        read_ok(GET, 3'd2, 4'd3);
        read_ok(GET, 3'd4, 4'd1);
        chk_count(3'd5);
    endtask

    task automatic test_pop();
        read_ok(POP, 3'd0, 4'd5);
        read_ok(POP, 3'd0, 4'd4);
        chk_count(3'd3);
    endtask

    task automatic test_hold();
        bus.RSP_READY = 1'b0;
        exp_q.push_back({1'b0, 4'd3});
        send(POP, 4'd0, 3'd0);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = PUSH;
        bus.REQ_DATA  = 4'd9;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 4'd3 || bus.REQ_READY !== 1'b0
                || bus.COMMAND !== NOP) begin
                errors++;
                $display("FAIL hold: rv=%0b rd=%0d rdy=%0b cmd=%0d, expected rv=1 rd=3 rdy=0 cmd=0",
                         bus.RSP_VALID, bus.RSP_DATA, bus.REQ_READY, bus.COMMAND);
            end
        end
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        bus.RSP_READY = 1'b1;
        drain();
        chk_count(3'd2);
    endtask

    task automatic rejected(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx);
        exp_q.push_back({1'b1, 4'd0});
        send(op, d, idx);
        @(negedge CLK);
        checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_ERR !== 1'b1 || bus.COMMAND !== NOP) begin
            errors++;
            $display("FAIL reject: rv=%0b err=%0b cmd=%0d, expected rv=1 err=1 cmd=0",
                     bus.RSP_VALID, bus.RSP_ERR, bus.COMMAND);
        end
        drain();
    endtask

    task automatic test_bounds();
`ifdef STACK_SEQ_BOUNDS_CHECK_EN
        rejected(GET, 4'd0, 3'd3);
        chk_count(3'd2);
        read_ok(POP, 3'd0, 4'd2);
        read_ok(POP, 3'd0, 4'd1);
        chk_count(3'd0);
        rejected(POP, 4'd0, 3'd0);
        chk_count(3'd0);
        for (int i = 6; i <= 10; i++) push_ok(4'(i), 3'(i - 5));
        rejected(PUSH, 4'd11, 3'd0);
        chk_count(3'd5);
        read_ok(POP, 3'd0, 4'd10);
`else
        read_ok(POP, 3'd0, 4'd2);
        read_ok(POP, 3'd0, 4'd1);
        read_ok(POP, 3'd0, 4'd0);
        chk_count(3'd0);
        for (int i = 6; i <= 10; i++) push_ok(4'(i), 3'(i - 5));
        push_ok(4'd11, 3'd5);
        read_ok(GET, 3'd0, 4'd11);
        read_ok(GET, 3'd4, 4'd7);
        read_ok(POP, 3'd0, 4'd11);
`endif
        chk_count(3'd4);
    endtask

    task automatic test_nop();
        exp_q.push_back({1'b0, 4'd0});
        send(NOP, 4'd7, 3'd0);
        @(negedge CLK);
        checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.COMMAND !== NOP) begin
            errors++;
            $display("FAIL nop: rv=%0b cmd=%0d, expected rv=1 cmd=0", bus.RSP_VALID, bus.COMMAND);
        end
        drain();
        chk_count(3'd4);
    endtask

    task automatic test_reset_mid_issue();
        send(PUSH, 4'd12, 3'd0);
        @(negedge CLK);
        checks++;
        if (bus.COMMAND !== PUSH || io_bus !== 4'd12) begin
            errors++;
            $display("FAIL mid_issue: cmd=%0d io=%0d, expected cmd=1 io=12", bus.COMMAND, io_bus);
        end
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.COMMAND !== NOP || bus.COUNT !== 3'd0 || bus.RSP_VALID !== 1'b0
            || bus.REQ_READY !== 1'b0 || io_bus === 4'd12) begin
            errors++;
            $display("FAIL async_reset: cmd=%0d cnt=%0d rv=%0b rdy=%0b io=%0d, expected 0 0 0 0 released",
                     bus.COMMAND, bus.COUNT, bus.RSP_VALID, bus.REQ_READY, io_bus);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rv=%0b rdy=%0b, expected 0 0", bus.RSP_VALID, bus.REQ_READY);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.REQ_READY !== 1'b1 || bus.RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ready_rise: rdy=%0b rv=%0b, expected 1 0", bus.REQ_READY, bus.RSP_VALID);
        end
        push_ok(4'd3, 3'd1);
        read_ok(GET, 3'd0, 4'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_OP    = NOP;
        bus.REQ_DATA  = 4'd0;
        bus.REQ_INDEX = 3'd0;
        bus.RSP_READY = 1'b1;
        test_reset();
        test_push();
        test_get();
        test_pop();
        test_hold();
        test_bounds();
        test_nop();
        test_reset_mid_issue();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses missing, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
